// File: rtl/connect4_win_detector.sv
`default_nettype none
// ============================================================================
// Module   : connect4_win_detector
// Desc     : Scans the board one anchor per cycle after each drop, reporting a win or draw.
//            Optional macro WIN_MASK_HIGHLIGHT_EN adds the winning-cell mask register.
// Revision : 1.0
// ============================================================================
module connect4_win_detector #(
  parameter int ROWS          = 6,
  parameter int COLS          = 7,
  parameter int WIN_LEN       = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 drop_en,
  input  logic [1:0]           grid [0:ROWS-1][0:COLS-1],
  output logic                 busy,
  output logic                 check_done,
  output logic                 game_over,
  output logic [1:0]           winner,
  output logic                 draw,
  output logic [2:0]           win_row,
  output logic [2:0]           win_col,
  output logic [1:0]           win_dir,
  output logic [ROWS*COLS-1:0] win_mask
);

  localparam logic [2:0] c_SETTLE   = 3'(SETTLE_CYCLES);
  localparam logic [2:0] c_LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0] c_LAST_COL = 3'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SCAN = 2'd2,
    S_OVER = 2'd3
  } state_t;

  // Direction steps: 0 right, 1 down, 2 down-right, 3 down-left
  function automatic int f_dr(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int f_dc(input int d);
    return (d == 1) ? 0 : ((d == 3) ? -1 : 1);
  endfunction

  state_t     r_state, w_state_next;
  logic [2:0] r_settle, w_settle_next;
  logic [2:0] r_row, w_row_next;
  logic [2:0] r_col, w_col_next;
  logic       r_pending, w_pending_next;
  logic       r_check_done, w_check_done_next;
  logic       r_game_over, w_game_over_next;
  logic [1:0] r_winner, w_winner_next;
  logic       r_draw, w_draw_next;
  logic [2:0] r_win_row, w_win_row_next;
  logic [2:0] r_win_col, w_win_col_next;
  logic [1:0] r_win_dir, w_win_dir_next;

  logic [1:0] w_anchor;
  logic [3:0] w_hit;
  logic       w_any_hit;
  logic [1:0] w_hit_dir;
  logic       w_row0_full;
  logic       w_last;

`ifdef WIN_MASK_HIGHLIGHT_EN
  localparam logic [ROWS*COLS-1:0] c_ONE = {{(ROWS*COLS-1){1'b0}}, 1'b1};
  logic [ROWS*COLS-1:0] w_line_mask [4];
  logic [ROWS*COLS-1:0] w_hit_mask;
  logic [ROWS*COLS-1:0] r_win_mask, w_win_mask_next;
`endif

  // All four lines from the current anchor are evaluated in parallel.
  always_comb begin
    int rr;
    int cc;
    rr          = 0;
    cc          = 0;
    w_anchor    = grid[r_row][r_col];
    w_hit       = '0;
    w_hit_dir   = 2'd0;
    w_row0_full = 1'b1;
`ifdef WIN_MASK_HIGHLIGHT_EN
    for (int d = 0; d < 4; d++) w_line_mask[d] = '0;
`endif
    for (int d = 0; d < 4; d++) begin
      w_hit[d] = (w_anchor == 2'b01) || (w_anchor == 2'b10);
      for (int i = 0; i < WIN_LEN; i++) begin
        rr = int'(r_row) + f_dr(d) * i;
        cc = int'(r_col) + f_dc(d) * i;
        if (rr >= ROWS || cc < 0 || cc >= COLS) begin
          w_hit[d] = 1'b0;
        end else begin
          if (grid[rr[2:0]][cc[2:0]] != w_anchor) w_hit[d] = 1'b0;
`ifdef WIN_MASK_HIGHLIGHT_EN
          w_line_mask[d] = w_line_mask[d] | (c_ONE << (rr * COLS + cc));
`endif
        end
      end
    end
    for (int d = 3; d >= 0; d--) begin
      if (w_hit[d]) w_hit_dir = 2'(d);
    end
    for (int c = 0; c < COLS; c++) begin
      if (grid[3'd0][3'(c)] == 2'b00) w_row0_full = 1'b0;
    end
  end

  assign w_any_hit = |w_hit;
  assign w_last    = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);

`ifdef WIN_MASK_HIGHLIGHT_EN
  assign w_hit_mask = w_line_mask[w_hit_dir];
`endif

  always_comb begin
    w_state_next      = r_state;
    w_settle_next     = r_settle;
    w_row_next        = r_row;
    w_col_next        = r_col;
    w_pending_next    = r_pending;
    w_check_done_next = 1'b0;
    w_game_over_next  = r_game_over;
    w_winner_next     = r_winner;
    w_draw_next       = r_draw;
    w_win_row_next    = r_win_row;
    w_win_col_next    = r_win_col;
    w_win_dir_next    = r_win_dir;
`ifdef WIN_MASK_HIGHLIGHT_EN
    w_win_mask_next   = r_win_mask;
`endif
    case (r_state)
      S_IDLE: begin
        if (drop_en) begin
          w_state_next  = S_WAIT;
          w_settle_next = 3'd0;
        end
      end
      S_WAIT: begin
        if (drop_en) w_pending_next = 1'b1;
        if (r_settle == c_SETTLE) begin
          w_state_next = S_SCAN;
          w_row_next   = 3'd0;
          w_col_next   = 3'd0;
        end else begin
          w_settle_next = r_settle + 3'd1;
        end
      end
      S_SCAN: begin
        if (drop_en) w_pending_next = 1'b1;
        if (w_any_hit) begin
          w_state_next      = S_OVER;
          w_check_done_next = 1'b1;
          w_game_over_next  = 1'b1;
          w_pending_next    = 1'b0;
          w_winner_next     = w_anchor;
          w_win_row_next    = r_row;
          w_win_col_next    = r_col;
          w_win_dir_next    = w_hit_dir;
`ifdef WIN_MASK_HIGHLIGHT_EN
          w_win_mask_next   = w_hit_mask;
`endif
        end else if (w_last) begin
          w_check_done_next = 1'b1;
          w_pending_next    = 1'b0;
          if (w_row0_full) begin
            w_state_next     = S_OVER;
            w_draw_next      = 1'b1;
            w_game_over_next = 1'b1;
          end else if (r_pending || drop_en) begin
            // A drop that lands on the final scan cycle still earns a rescan.
            w_state_next  = S_WAIT;
            w_settle_next = 3'd0;
          end else begin
            w_state_next = S_IDLE;
          end
        end else if (r_col == c_LAST_COL) begin
          w_col_next = 3'd0;
          w_row_next = r_row + 3'd1;
        end else begin
          w_col_next = r_col + 3'd1;
        end
      end
      S_OVER: begin
        w_state_next = S_OVER;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state      <= S_IDLE;
      r_settle     <= 3'd0;
      r_row        <= 3'd0;
      r_col        <= 3'd0;
      r_pending    <= 1'b0;
      r_check_done <= 1'b0;
      r_game_over  <= 1'b0;
      r_winner     <= 2'b00;
      r_draw       <= 1'b0;
      r_win_row    <= 3'd0;
      r_win_col    <= 3'd0;
      r_win_dir    <= 2'd0;
    end else begin
      r_state      <= w_state_next;
      r_settle     <= w_settle_next;
      r_row        <= w_row_next;
      r_col        <= w_col_next;
      r_pending    <= w_pending_next;
      r_check_done <= w_check_done_next;
      r_game_over  <= w_game_over_next;
      r_winner     <= w_winner_next;
      r_draw       <= w_draw_next;
      r_win_row    <= w_win_row_next;
      r_win_col    <= w_win_col_next;
      r_win_dir    <= w_win_dir_next;
    end
  end

`ifdef WIN_MASK_HIGHLIGHT_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_win_mask <= '0;
    else       r_win_mask <= w_win_mask_next;
  end
  assign win_mask = r_win_mask;
`else
  assign win_mask = '0;
`endif

  assign busy       = (r_state == S_WAIT) || (r_state == S_SCAN);
  assign check_done = r_check_done;
  assign game_over  = r_game_over;
  assign winner     = r_winner;
  assign draw       = r_draw;
  assign win_row    = r_win_row;
  assign win_col    = r_win_col;
  assign win_dir    = r_win_dir;

endmodule
`default_nettype wire

// File: tb/tb_connect4_win_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_connect4_win_detector
// Desc     : Directed and random boards checked against a line-enumerating reference model.
// Revision : 1.0
// ============================================================================
module tb_connect4_win_detector;

  localparam int ROWS   = 6;
  localparam int COLS   = 7;
  localparam int WLEN   = 4;
  localparam int SETTLE = 1;

  logic                 clk;
  logic                 rst_n;
  logic                 drop_en;
  logic [1:0]           grid [0:ROWS-1][0:COLS-1];
  logic                 busy;
  logic                 check_done;
  logic                 game_over;
  logic [1:0]           winner;
  logic                 draw;
  logic [2:0]           win_row;
  logic [2:0]           win_col;
  logic [1:0]           win_dir;
  logic [ROWS*COLS-1:0] win_mask;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int DR [4] = '{0, 1, 1, 1};
  int DC [4] = '{1, 0, 1, -1};

  connect4_win_detector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .drop_en   (drop_en),
    .grid      (grid),
    .busy      (busy),
    .check_done(check_done),
    .game_over (game_over),
    .winner    (winner),
    .draw      (draw),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_dir   (win_dir),
    .win_mask  (win_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_grid();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) grid[r][c] = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    drop_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " check_done"}, 64'(check_done), 64'd0);
    check({tag, " game_over"}, 64'(game_over), 64'd0);
    check({tag, " winner"}, 64'(winner), 64'd0);
    check({tag, " draw"}, 64'(draw), 64'd0);
    check({tag, " win_pos"}, 64'({win_row, win_col, win_dir}), 64'd0);
    check({tag, " win_mask"}, 64'(win_mask), 64'd0);
  endtask

  // Drives a single-cycle drop_en captured by the next rising edge.
  task automatic pulse_drop();
    @(negedge clk);
    drop_en = 1'b1;
    @(posedge clk);
    #1;
    drop_en = 1'b0;
  endtask

  // Enumerates every possible line; the winning line is the one with the smallest
  // (anchor index, direction) key. A board whose top row has no gaps is full.
  function automatic void ref_eval(output int k, output int dir, output int p,
                                   output bit full, output logic [63:0] mask);
    int best;
    int rr;
    int cc;
    bit ok;
    logic [1:0] v;
    best = -1;
    k = -1;
    dir = 0;
    p = 0;
    mask = '0;
    full = 1'b1;
    for (int c = 0; c < COLS; c++) if (grid[0][c] == 2'b00) full = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        for (int d = 0; d < 4; d++) begin
          v  = grid[r][c];
          ok = (v == 2'b01) || (v == 2'b10);
          for (int i = 1; i < WLEN; i++) begin
            rr = r + DR[d] * i;
            cc = c + DC[d] * i;
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 1'b0;
            else if (grid[rr][cc] != v) ok = 1'b0;
          end
          if (ok && (best < 0 || (r * COLS + c) * 4 + d < best)) begin
            best = (r * COLS + c) * 4 + d;
            p = int'(v);
            mask = '0;
            for (int i = 0; i < WLEN; i++)
              mask[(r + DR[d] * i) * COLS + (c + DC[d] * i)] = 1'b1;
          end
        end
      end
    end
    if (best >= 0) begin
      k   = best / 4;
      dir = best % 4;
    end
  endfunction

  task automatic run_scan(input string tag);
    int k, dir, p, lat, exp_lat;
    bit full, busy_bad, won;
    logic [63:0] mask;
    ref_eval(k, dir, p, full, mask);
    won = (k >= 0);
    exp_lat = won ? (SETTLE + k + 2) : (SETTLE + ROWS * COLS + 1);
    pulse_drop();
    lat = 0;
    busy_bad = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (check_done) begin
        lat = n;
        break;
      end
      if (!busy) busy_bad = 1'b1;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy_during"}, 64'(busy_bad), 64'd0);
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " winner"}, 64'(winner), 64'(p));
    check({tag, " draw"}, 64'(draw), 64'(!won && full));
    check({tag, " game_over"}, 64'(game_over), 64'(won || full));
    check({tag, " win_row"}, 64'(win_row), won ? 64'(k / COLS) : 64'd0);
    check({tag, " win_col"}, 64'(win_col), won ? 64'(k % COLS) : 64'd0);
    check({tag, " win_dir"}, 64'(win_dir), won ? 64'(dir) : 64'd0);
`ifdef WIN_MASK_HIGHLIGHT_EN
    check({tag, " win_mask"}, 64'(win_mask), mask);
`else
    check({tag, " win_mask"}, 64'(win_mask), 64'd0);
`endif
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, 64'(check_done), 64'd0);
  endtask

  initial begin
    int pulses, first_at, second_at, thresh, pick;
    bit saw_busy;
    rst_n   = 1'b1;
    drop_en = 1'b0;
    clear_grid();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset");

    // Empty board: full-length scan, nothing found
    run_scan("empty");
    check("empty expected_lat44", 64'(SETTLE + ROWS * COLS + 1), 64'd44);

    do_reset();
    clear_grid();
    for (int c = 0; c < 4; c++) grid[5][c] = 2'b01;
    run_scan("row5_p1");
    check("row5_p1 fixed_winner", 64'({winner, win_row, win_col, win_dir}), 64'({2'b01, 3'd5, 3'd0, 2'd0}));

    do_reset();
    clear_grid();
    for (int r = 2; r < 6; r++) grid[r][6] = 2'b10;
    run_scan("col6_p2");
    check("col6_p2 fixed_winner", 64'({winner, win_row, win_col, win_dir}), 64'({2'b10, 3'd2, 3'd6, 2'd1}));

    do_reset();
    clear_grid();
    for (int i = 0; i < 4; i++) grid[2 + i][i] = 2'b01;
    run_scan("diag_dr");
    check("diag_dr fixed_winner", 64'({winner, win_row, win_col, win_dir}), 64'({2'b01, 3'd2, 3'd0, 2'd2}));

    do_reset();
    clear_grid();
    for (int i = 0; i < 4; i++) grid[2 + i][6 - i] = 2'b10;
    run_scan("diag_dl");
    check("diag_dl fixed_winner", 64'({winner, win_row, win_col, win_dir}), 64'({2'b10, 3'd2, 3'd6, 2'd3}));

    // Full board, runs never longer than two in any direction
    do_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) grid[r][c] = (((r / 2) + c) % 2 == 0) ? 2'b01 : 2'b10;
    run_scan("full");
    check("full fixed_draw", 64'({draw, game_over, winner}), 64'({1'b1, 1'b1, 2'b00}));
    pulse_drop();
    pulses = 0;
    saw_busy = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (check_done) pulses++;
      if (busy) saw_busy = 1'b1;
    end
    check("over drop_pulses", 64'(pulses), 64'd0);
    check("over drop_busy", 64'(saw_busy), 64'd0);
    check("over sticky", 64'({draw, game_over}), 64'({1'b1, 1'b1}));

    // Drops while busy collapse into a single rescan
    do_reset();
    clear_grid();
    pulse_drop();
    pulses = 0;
    first_at = 0;
    second_at = 0;
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      drop_en = (n == 10) || (n == 15);
      @(posedge clk);
      #1;
      if (check_done) begin
        pulses++;
        if (pulses == 1) first_at = n;
        else if (pulses == 2) second_at = n;
      end
    end
    drop_en = 1'b0;
    check("pending pulses", 64'(pulses), 64'd2);
    check("pending first_at", 64'(first_at), 64'd44);
    check("pending second_at", 64'(second_at), 64'd88);

    // Asynchronous reset in the middle of a scan
    do_reset();
    clear_grid();
    for (int c = 0; c < 4; c++) grid[5][c] = 2'b10;
    pulse_drop();
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check_idle_outputs("midscan_rst");
    @(negedge clk);
    rst_n = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (check_done) pulses++;
    end
    check("midscan_rst no_done", 64'(pulses), 64'd0);

    // Random boards, including invalid 11 cells
    for (int t = 0; t < 24; t++) begin
      do_reset();
      thresh = (t % 2 == 0) ? 55 : 8;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          pick = int'($urandom_range(0, 99));
          if (pick < thresh) grid[r][c] = 2'b00;
          else if (pick < thresh + (100 - thresh) * 45 / 100) grid[r][c] = 2'b01;
          else if (pick < 96) grid[r][c] = 2'b10;
          else grid[r][c] = 2'b11;
        end
      end
      run_scan($sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/connect4_win_detector.md
Name: connect4_win_detector

Overview:
- Game-state stage directly downstream of the grid logic. Consumes the placed-piece grid and the drop_en pulse.
- After every accepted drop, sequentially scans the 6x7 board for WIN_LEN in a row (horizontal, vertical, both diagonals) and checks for a full board.
- Reports winner/draw and a sticky game_over that the top level uses to lock out further drops and to drive the renderer's end-of-game indication.

Parameters:
- ROWS, 6, board rows; row 0 = top, row ROWS-1 = bottom.
- COLS, 7, board columns; col 0 = left.
- WIN_LEN, 4, consecutive equal cells required to win (2..min(ROWS,COLS)).
- SETTLE_CYCLES, 1, cycles waited after drop_en before scanning, so grid reflects the new piece (1..7).

Ports:
- clk  in  1  pixel-domain clock (clk_25 at top level).
- rst_n  in  1  asynchronous, active-high reset; the port keeps the codebase name rst_n but asserts high.
- drop_en  in  1  single-cycle pulse, piece accepted by grid logic.
- grid  in  2 x [0:ROWS-1][0:COLS-1]  unpacked cell array, same shape as grid_logic grid_out; 00 empty, 01 player 1, 10 player 2, 11 invalid.
- busy  out  1  high while waiting or scanning.
- check_done  out  1  one-cycle pulse when a check completes (any outcome).
- game_over  out  1  sticky; set on win or draw.
- winner  out  2  01/10 = winning player; 00 = none/draw.
- draw  out  1  sticky; board full, no winner.
- win_row  out  3  anchor row of winning line.
- win_col  out  3  anchor column of winning line.
- win_dir  out  2  0 = right, 1 = down, 2 = down-right, 3 = down-left (from anchor).
- win_mask  out  ROWS*COLS  winning-cell mask, bit index r*COLS+c (see Optional Feature).

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; pending flag 0; counters 0.
- FSM states: IDLE, WAIT, SCAN, OVER.
  - IDLE: drop_en=1 -> WAIT, settle counter = 0.
  - WAIT: count SETTLE_CYCLES cycles -> SCAN, anchor index = 0.
  - SCAN: evaluate one anchor (r,c) per cycle, row-major (index r*COLS+c, 0..ROWS*COLS-1). All 4 directions are checked combinationally.
- Direction hit conditions:
  - Anchor value is 01 or 10.
  - All WIN_LEN-1 further cells in that direction are in bounds and equal to the anchor.
  - Out-of-bounds lines never match.
  - 11 never matches.
- Priority for the same anchor: right > down > down-right > down-left.
- First hit (lowest index): next edge latches winner, win_row, win_col, win_dir; sets game_over; pulses check_done; -> OVER.
- Last anchor with no hit:
  - If every row-0 cell is non-00: set draw and game_over, pulse check_done, -> OVER.
  - Otherwise pulse check_done; -> WAIT if pending else IDLE; clear pending.
- Latency: with no win, check_done is high exactly SETTLE_CYCLES+ROWS*COLS+1 cycles after the edge that samples drop_en (44 with defaults). A win at anchor k asserts check_done at SETTLE_CYCLES+k+2.
- busy = 1 in WAIT and SCAN, 0 otherwise.
- drop_en during WAIT/SCAN sets pending; a rescan starts from WAIT after the current check. Multiple drops collapse into one pending.
- drop_en in OVER is ignored; OVER is left only by reset.
- Simultaneous drop_en and scan completion without win: treated as pending (rescan occurs).
- Board never mutates mid-scan in normal play; if it does, the result reflects per-cycle sampling and is undefined.

Optional Feature:
- Macro WIN_MASK_HIGHLIGHT_EN.
- Defined: on a win, win_mask bits for the WIN_LEN winning cells are set in the same edge as winner. Cleared only by reset.
- Undefined: win_mask is constant 0 and no mask registers are generated.

Test Plan:
- Reset, then drop_en with empty grid -> busy for 43 cycles, check_done at cycle 44, winner=00, draw=0, game_over=0.
- Row 5 cols 0..3 = 01 -> check_done at cycle 2+35+...: winner=01, win_row=5, win_col=0, win_dir=0, game_over=1; with macro, win_mask bits 35..38 set.
- Col 6 rows 2..5 = 10 -> winner=10, win_row=2, win_col=6, win_dir=1.
- Diagonals:
  - (2,0),(3,1),(4,2),(5,3) = 01 -> win_dir=2, anchor (2,0).
  - (2,6),(3,5),(4,4),(5,3) = 10 -> win_dir=3, anchor (2,6).
- Full board, alternating pattern with no 4-run -> check_done, draw=1, winner=00, game_over=1; a later drop_en produces no new check_done.
- Two drops 10 cycles apart -> exactly two check_done pulses, second at 44 cycles after the first completes. Assert rst_n mid-scan -> all outputs 0 immediately, no check_done.
